instr_decode_queue: RTL and testbench
=====================================

INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered decoded entries; power of two, 2..16.
REQ-002 Parameter EXT_EN, default 1; 1 = all 54 instructions legal, 0 = only code bits 0..30 legal.
REQ-003 Parameter PC_W, default 32, width of the carried PC tag.
REQ-004 clk  in  1  rising-edge clock; the only clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discard all buffered entries (branch redirect or exception).
REQ-007 in_valid  in  1  producer presents an instruction.
REQ-008 in_ready  out  1  queue can accept; equals (count < DEPTH), combinational from state only.
REQ-009 in_instr  in  32  raw MIPS32 instruction.
REQ-010 in_pc  in  PC_W  PC of in_instr.
REQ-011 out_valid  out  1  head entry present (count != 0).
REQ-012 out_ready  in  1  consumer takes the head entry.
REQ-013 out_code  out  54  one-hot decode of the head entry; all-zero when illegal.
REQ-014 out_index  out  6  binary index of the set out_code bit; 6'd63 when illegal.
REQ-015 out_illegal  out  1  head instruction matches no legal encoding.
REQ-016 out_instr / out_pc  out  32 / PC_W  head raw instruction and PC, passed through unchanged.
REQ-017 count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Decode occurs on the write side; each entry stores {code, index, illegal, instr, pc}.
REQ-019 Code bit map: 0 add,1 addu,2 sub,3 subu,4 and,5 or,6 xor,7 nor,8 slt,9 sltu,10 sll,11 srl,12 sra,13 sllv,14 srlv,15 srav,16 jr,17 addi,18 addiu,19 andi,20 ori,21 xori,22 lui,23 lw,24 sw,25 beq,26 bne,27 slti,28 sltiu,29 j,30 jal.
REQ-020 Code bit map (cont.): 31 clz,32 divu,33 div,34 mul,35 multu,36 jalr,37 bgez,38 lh,39 lb,40 lbu,41 lhu,42 sb,43 sh,44 mfc0,45 mtc0,46 mfhi,47 mthi,48 mflo,49 mtlo,50 eret,51 syscall,52 teq,53 break.
REQ-021 Matching: R-type on op 000000 + funct; I/J-type on op only; clz/mul on op 011100 + funct 100000/000010; mfc0 on instr[31:21]=01000000000; mtc0 on instr[31:21]=01000000100; eret only on exact 32'h42000018.
REQ-022 Exactly one code bit is set for any legal instruction; never X or Z on any output.
REQ-023 Unmatched encoding, or a match on bit >= 31 with EXT_EN=0: code 0, index 63, illegal 1; the entry is still queued in order.
REQ-024 Latency: entry accepted at edge N appears on the out_* outputs after edge N when the queue was empty; no combinational path from in_* to out_*.
REQ-025 Push occurs when in_valid & in_ready; pop occurs when out_valid & out_ready; both on the same edge leave count unchanged.
REQ-026 Simultaneous push and pop while full: in_ready=0, so only the pop occurs; count decrements.
REQ-027 Read and write pointers wrap modulo DEPTH; order is strict FIFO.
REQ-028 flush: count, read pointer and write pointer go to 0 at the edge; a push or pop in the same cycle is ignored.
REQ-029 Out data is held stable while out_valid=1 and out_ready=0.
REQ-030 Pop with count=0 and push with count=DEPTH have no effect on any state.

Reset
REQ-031 When rst=1 at a rising edge: count=0, pointers=0, out_valid=0, in_ready=1; rst has priority over flush, push and pop.
REQ-032 Out data after reset is all zeros, with out_index=63 and out_illegal=0 until the first push.
REQ-033 Storage contents need no reset; they are never visible while out_valid=0.

Verification
REQ-034 Push 32'h012A4020 (add), then 32'h8D090004 (lw) -> out_code bit 0 with index 0, then bit 23 with index 23; one cycle latency each.
REQ-035 Push 32'h40086000 (mfc0), 32'h40886000 (mtc0), 32'h42000018 (eret), 32'h42100018 -> indices 44, 45, 50, then illegal (index 63).
REQ-036 EXT_EN=0: push 32'h7109_0002 (mul) -> out_illegal=1, out_code=0; EXT_EN=1 -> index 34.
REQ-037 DEPTH=4 with out_ready=0: push 5 times -> count=4, in_ready=0, fifth push is dropped; then drain 4 -> original order preserved across pointer wrap.
REQ-038 Full queue with in_valid=1 and out_ready=1 -> pop only, count 4->3; next cycle push and pop together -> count stays 3.
REQ-039 count=3 with flush and in_valid=1 in the same cycle -> count=0, out_valid=0 next cycle; rst asserted mid-stream -> same result.

Source files
------------

// File: rtl/instr_decode_queue.sv
// Decoding instruction queue: MIPS32 instructions are one-hot decoded on the write
// side and buffered with their PC in a DEPTH-entry FIFO that supports flush.
module instr_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int EXT_EN = 1,
  parameter int PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [53:0]                out_code,
  output logic [5:0]                 out_index,
  output logic                       out_illegal,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [5:0] NONE = 6'd63;

  typedef struct packed {
    logic [53:0]     code;
    logic [5:0]      index;
    logic            illegal;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  function automatic logic [5:0] decode_index(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    op = i[31:26];
    fn = i[5:0];
    decode_index = NONE;
    if (i == 32'h4200_0018)               decode_index = 6'd50;
    else if (i[31:21] == 11'b01000000000) decode_index = 6'd44;
    else if (i[31:21] == 11'b01000000100) decode_index = 6'd45;
    else begin
      case (op)
        6'b000000: begin
          case (fn)
            6'b100000: decode_index = 6'd0;
            6'b100001: decode_index = 6'd1;
            6'b100010: decode_index = 6'd2;
            6'b100011: decode_index = 6'd3;
            6'b100100: decode_index = 6'd4;
            6'b100101: decode_index = 6'd5;
            6'b100110: decode_index = 6'd6;
            6'b100111: decode_index = 6'd7;
            6'b101010: decode_index = 6'd8;
            6'b101011: decode_index = 6'd9;
            6'b000000: decode_index = 6'd10;
            6'b000010: decode_index = 6'd11;
            6'b000011: decode_index = 6'd12;
            6'b000100: decode_index = 6'd13;
            6'b000110: decode_index = 6'd14;
            6'b000111: decode_index = 6'd15;
            6'b001000: decode_index = 6'd16;
            6'b011011: decode_index = 6'd32;
            6'b011010: decode_index = 6'd33;
            6'b011001: decode_index = 6'd35;
            6'b001001: decode_index = 6'd36;
            6'b010000: decode_index = 6'd46;
            6'b010001: decode_index = 6'd47;
            6'b010010: decode_index = 6'd48;
            6'b010011: decode_index = 6'd49;
            6'b001100: decode_index = 6'd51;
            6'b110100: decode_index = 6'd52;
            6'b001101: decode_index = 6'd53;
            default:   decode_index = NONE;
          endcase
        end
        6'b011100: begin
          if (fn == 6'b100000)      decode_index = 6'd31;
          else if (fn == 6'b000010) decode_index = 6'd34;
        end
        6'b001000: decode_index = 6'd17;
        6'b001001: decode_index = 6'd18;
        6'b001100: decode_index = 6'd19;
        6'b001101: decode_index = 6'd20;
        6'b001110: decode_index = 6'd21;
        6'b001111: decode_index = 6'd22;
        6'b100011: decode_index = 6'd23;
        6'b101011: decode_index = 6'd24;
        6'b000100: decode_index = 6'd25;
        6'b000101: decode_index = 6'd26;
        6'b001010: decode_index = 6'd27;
        6'b001011: decode_index = 6'd28;
        6'b000010: decode_index = 6'd29;
        6'b000011: decode_index = 6'd30;
        6'b000001: decode_index = 6'd37;
        6'b100001: decode_index = 6'd38;
        6'b100000: decode_index = 6'd39;
        6'b100100: decode_index = 6'd40;
        6'b100101: decode_index = 6'd41;
        6'b101000: decode_index = 6'd42;
        6'b101001: decode_index = 6'd43;
        default:   decode_index = NONE;
      endcase
    end
  endfunction

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  entry_t          in_entry;
  entry_t          out_entry;
  logic [5:0]      in_idx;
  logic            in_legal;
  logic            push;
  logic            pop;

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush & ~rst;
  assign pop       = out_valid & out_ready & ~flush & ~rst;
  assign count     = count_q;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    in_entry       = '0;
    in_idx         = decode_index(in_instr);
    in_legal       = (in_idx != NONE) && ((EXT_EN != 0) || (in_idx < 6'd31));
    in_entry.code  = in_legal ? (54'd1 << in_idx) : 54'd0;
    in_entry.index = in_legal ? in_idx : NONE;
    in_entry.illegal = ~in_legal;
    in_entry.instr = in_instr;
    in_entry.pc    = in_pc;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; its contents are masked on the outputs while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_comb begin
    out_entry       = '0;
    out_entry.index = NONE;
    if (out_valid) out_entry = mem[rd_ptr];
  end

  assign out_code    = out_entry.code;
  assign out_index   = out_entry.index;
  assign out_illegal = out_entry.illegal;
  assign out_instr   = out_entry.instr;
  assign out_pc      = out_entry.pc;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed bench for instr_decode_queue: decode map, FIFO ordering, full/empty
// corner cases, flush and reset, with an EXT_EN=0 instance sharing the inputs.
module tb_instr_decode_queue;

  logic        clk = 0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [53:0] out_code;
  logic [5:0]  out_index;
  logic [31:0] out_instr, out_pc;
  logic [2:0]  count;

  logic        x_in_ready, x_out_valid, x_out_illegal;
  logic [53:0] x_out_code;
  logic [5:0]  x_out_index;
  logic [31:0] x_out_instr, x_out_pc;
  logic [2:0]  x_count;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADD = 32'h012A_4020;

  instr_decode_queue #(.DEPTH(4), .EXT_EN(1), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_index(out_index), .out_illegal(out_illegal),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  instr_decode_queue #(.DEPTH(4), .EXT_EN(0), .PC_W(32)) dut_x (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(x_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(x_out_valid), .out_ready(out_ready),
    .out_code(x_out_code), .out_index(x_out_index), .out_illegal(x_out_illegal),
    .out_instr(x_out_instr), .out_pc(x_out_pc), .count(x_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy);
    in_valid  = v;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = rdy;
  endtask

  initial begin
    rst = 1; flush = 0;
    drive(0, 32'h0, 32'h0, 0);
    tick(); tick();
    rst = 0;

    check("rst_valid",   64'(out_valid),   64'd0);
    check("rst_ready",   64'(in_ready),    64'd1);
    check("rst_count",   64'(count),       64'd0);
    check("rst_index",   64'(out_index),   64'd63);
    check("rst_illegal", 64'(out_illegal), 64'd0);
    check("rst_code",    64'(out_code),    64'd0);
    check("rst_instr",   64'(out_instr),   64'd0);

    // add, then lw pushed while add is popped
    drive(1, ADD, 32'h100, 0);
    #1;
    check("no_comb_path", 64'(out_valid), 64'd0);
    tick();
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_code",  64'(out_code),  64'd1);
    check("add_index", 64'(out_index), 64'd0);
    check("add_pc",    64'(out_pc),    64'h100);
    check("add_instr", 64'(out_instr), 64'(ADD));
    check("x_add_index", 64'(x_out_index), 64'd0);
    drive(1, 32'h8D09_0004, 32'h104, 1);
    tick();
    check("pushpop_count", 64'(count),     64'd1);
    check("lw_index",      64'(out_index), 64'd23);
    check("lw_code",       64'(out_code),  64'd1 << 23);
    drive(0, 32'h0, 32'h0, 1);
    tick();
    check("empty_valid", 64'(out_valid), 64'd0);
    check("empty_index", 64'(out_index), 64'd63);
    tick();
    check("pop_empty_count", 64'(count), 64'd0);

    // cop0 / eret group fills the queue exactly
    drive(1, 32'h4008_6000, 32'h200, 0); tick();
    drive(1, 32'h4088_6000, 32'h204, 0); tick();
    drive(1, 32'h4200_0018, 32'h208, 0); tick();
    drive(1, 32'h4210_0018, 32'h20C, 0); tick();
    check("cop_full_count", 64'(count),    64'd4);
    check("cop_full_ready", 64'(in_ready), 64'd0);
    check("mfc0_index",   64'(out_index),   64'd44);
    check("x_mfc0_ill",   64'(x_out_illegal), 64'd1);
    drive(0, 32'h0, 32'h0, 1);
    tick();
    check("mtc0_index",   64'(out_index), 64'd45);
    tick();
    check("eret_index",   64'(out_index), 64'd50);
    check("eret_code",    64'(out_code),  64'd1 << 50);
    tick();
    check("bad_index",    64'(out_index),   64'd63);
    check("bad_illegal",  64'(out_illegal), 64'd1);
    check("bad_code",     64'(out_code),    64'd0);
    tick();
    check("cop_drained",  64'(count), 64'd0);

    // mul legal only with extensions enabled
    drive(1, 32'h7109_0002, 32'h300, 0);
    tick();
    check("mul_index",    64'(out_index),     64'd34);
    check("x_mul_ill",    64'(x_out_illegal), 64'd1);
    check("x_mul_code",   64'(x_out_code),    64'd0);
    check("x_mul_index",  64'(x_out_index),   64'd63);
    drive(0, 32'h0, 32'h0, 1);
    tick();

    // overfill, full push+pop, then drain across pointer wrap
    for (int k = 0; k < 5; k++) begin
      drive(1, ADD, 32'h10 + 32'(4 * k), 0);
      tick();
    end
    check("ovf_count", 64'(count),    64'd4);
    check("ovf_ready", 64'(in_ready), 64'd0);
    check("ovf_head",  64'(out_pc),   64'h10);
    drive(1, ADD, 32'h24, 0);
    tick();
    check("hold_head", 64'(out_pc), 64'h10);
    drive(1, ADD, 32'h24, 1);
    tick();
    check("full_pop_count", 64'(count),  64'd3);
    check("full_pop_head",  64'(out_pc), 64'h14);
    drive(1, ADD, 32'h28, 1);
    tick();
    check("pp3_count", 64'(count),  64'd3);
    check("pp3_head",  64'(out_pc), 64'h18);
    drive(0, 32'h0, 32'h0, 1);
    tick();
    check("drain_1c", 64'(out_pc), 64'h1C);
    tick();
    check("drain_28", 64'(out_pc), 64'h28);
    tick();
    check("drain_empty", 64'(out_valid), 64'd0);

    // flush with a concurrent push
    for (int k = 0; k < 3; k++) begin
      drive(1, ADD, 32'h400 + 32'(k), 0);
      tick();
    end
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1;
    drive(1, ADD, 32'h4FF, 1);
    tick();
    flush = 0;
    check("flush_count", 64'(count),     64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);

    // reset mid-stream with push, pop and flush all asserted
    drive(1, ADD, 32'h500, 0); tick();
    drive(1, ADD, 32'h504, 0); tick();
    check("pre_rst_count", 64'(count), 64'd2);
    rst = 1; flush = 1;
    drive(1, ADD, 32'h508, 1);
    tick();
    rst = 0; flush = 0;
    drive(0, 32'h0, 32'h0, 0);
    check("mid_rst_count", 64'(count),     64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd1);
    check("mid_rst_index", 64'(out_index), 64'd63);
    check("x_mid_rst_count", 64'(x_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
